// File: rtl/srb_pkg.sv
// rtl/srb_pkg.sv - shared types and width helpers for the sparse reorder buffer
package srb_pkg;

    // Lifecycle of one reorder-buffer entry
    typedef enum logic [1:0] {
        SRB_FREE   = 2'd0,
        SRB_ALLOC  = 2'd1,
        SRB_FILLED = 2'd2
    } srb_state_e;

    localparam int SRB_DEPTH_DEF = 16;
    localparam int SRB_WIDTH_DEF = 32;

    // Tag/index width for a given depth
    function automatic int srb_tag_w(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width: one extra MSB tells full apart from empty
    function automatic int srb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sparse_reorder_buffer_if.sv
// rtl/sparse_reorder_buffer_if.sv - alloc/fill/drain/status bundle of the reorder buffer
interface sparse_reorder_buffer_if
    import srb_pkg::*;
#(
    parameter int DEPTH = SRB_DEPTH_DEF,
    parameter int WIDTH = SRB_WIDTH_DEF
);
    localparam int TAG_W = srb_tag_w(DEPTH);

    logic             alloc_valid;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             fill_valid;
    logic [TAG_W-1:0] fill_tag;
    logic [WIDTH-1:0] fill_data;
    logic             drain_valid;
    logic             drain_ready;
    logic [WIDTH-1:0] drain_data;
    logic [TAG_W-1:0] drain_tag;
    logic             flush;
    logic             fill_err;
    logic [TAG_W:0]   occupancy;
    logic [DEPTH-1:0] entry_filled;
    logic             full;
    logic             empty;

    // Requester / filler / consumer side
    modport master (
        output alloc_valid, fill_valid, fill_tag, fill_data, drain_ready, flush,
        input  alloc_ready, alloc_tag, drain_valid, drain_data, drain_tag,
        input  fill_err, occupancy, entry_filled, full, empty
    );

    // Reorder buffer side
    modport slave (
        input  alloc_valid, fill_valid, fill_tag, fill_data, drain_ready, flush,
        output alloc_ready, alloc_tag, drain_valid, drain_data, drain_tag,
        output fill_err, occupancy, entry_filled, full, empty
    );
endinterface

// File: rtl/srb_ptr_ctrl.sv
// rtl/srb_ptr_ctrl.sv - head/tail pointers with occupancy, full and empty
module srb_ptr_ctrl
    import srb_pkg::*;
#(
    parameter  int DEPTH = SRB_DEPTH_DEF,
    localparam int PTR_W = srb_ptr_w(DEPTH),
    localparam int TAG_W = srb_tag_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_tail,
    input  logic             inc_head,
    input  logic             clear,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [PTR_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    // Next pointers; clear wins over any advance in the same cycle
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (inc_head) head_d = head_q + PTR_W'(1);
            if (inc_tail) tail_d = tail_q + PTR_W'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head      = head_q;
    assign tail      = tail_q;
    assign occupancy = tail_q - head_q;
    assign empty     = (head_q == tail_q);
    assign full      = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                       (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]);

endmodule

// File: rtl/sparse_reorder_buffer.sv
// rtl/sparse_reorder_buffer.sv - in-order tag issue, any-order fill, in-order drain
module sparse_reorder_buffer
    import srb_pkg::*;
#(
    parameter int DEPTH = SRB_DEPTH_DEF,
    parameter int WIDTH = SRB_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    sparse_reorder_buffer_if.slave bus
);
    localparam int TAG_W = srb_tag_w(DEPTH);

    logic [TAG_W:0]   head, tail, occupancy;
    logic             full, empty;
    logic [TAG_W-1:0] head_idx, tail_idx;

    srb_state_e       state_q [DEPTH];
    srb_state_e       state_d [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic             fill_err_q, fill_err_d;

    logic             alloc_fire, drain_fire, drain_valid;
    logic             fill_ok, fill_bad;
    logic [DEPTH-1:0] entry_filled;

    srb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rstn      (rstn),
        .inc_tail  (alloc_fire),
        .inc_head  (drain_fire),
        .clear     (bus.flush),
        .head      (head),
        .tail      (tail),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    // alloc_ready looks only at registered fullness: no bypass from a same-cycle drain
    assign alloc_fire  = bus.alloc_valid && !full && !bus.flush;
    assign drain_valid = !empty && (state_q[head_idx] == SRB_FILLED);
    assign drain_fire  = drain_valid && bus.drain_ready && !bus.flush;

    // Classify a fill: only an ALLOC entry accepts data; flush drops fills silently
    always_comb begin
        fill_ok  = 1'b0;
        fill_bad = 1'b0;
        if (bus.fill_valid && !bus.flush) begin
            if (state_q[bus.fill_tag] == SRB_ALLOC) fill_ok  = 1'b1;
            else                                    fill_bad = 1'b1;
        end
    end

    // Per-entry next state and data; alloc, fill and drain always touch distinct entries
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
        end
        fill_err_d = fill_bad;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) state_d[i] = SRB_FREE;
        end else begin
            if (alloc_fire) state_d[tail_idx] = SRB_ALLOC;
            if (fill_ok) begin
                state_d[bus.fill_tag] = SRB_FILLED;
                data_d[bus.fill_tag]  = bus.fill_data;
            end
            if (drain_fire) state_d[head_idx] = SRB_FREE;
        end
    end

    // Entry states and the error pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= SRB_FREE;
            fill_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_err_q <= fill_err_d;
        end
    end

    // Data array carries no reset; it is only observed once an entry is FILLED
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Per-entry FILLED flags for status
    always_comb begin
        entry_filled = '0;
        for (int i = 0; i < DEPTH; i++) entry_filled[i] = (state_q[i] == SRB_FILLED);
    end

    assign bus.alloc_ready  = !full;
    assign bus.alloc_tag    = tail_idx;
    assign bus.drain_valid  = drain_valid;
    assign bus.drain_data   = data_q[head_idx];
    assign bus.drain_tag    = head_idx;
    assign bus.fill_err     = fill_err_q;
    assign bus.occupancy    = occupancy;
    assign bus.entry_filled = entry_filled;
    assign bus.full         = full;
    assign bus.empty        = empty;

endmodule

// File: tb/tb_sparse_reorder_buffer.sv
// tb/tb_sparse_reorder_buffer.sv - scoreboard bench for sparse_reorder_buffer
module tb_sparse_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int WIDTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sparse_reorder_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sparse_reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    int          m_head = 0;
    int          m_tail = 0;
    int          m_state [DEPTH];
    logic [31:0] m_data  [DEPTH];
    bit          m_err = 0;
    int          exp_q [$];

    task automatic idle_inputs();
        bus.alloc_valid = 1'b0;
        bus.fill_valid  = 1'b0;
        bus.fill_tag    = '0;
        bus.fill_data   = '0;
        bus.drain_ready = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        m_err  = 0;
        for (int i = 0; i < DEPTH; i++) m_state[i] = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, advance the model from its own pre-edge state
    task automatic step(input bit av, input bit fv, input int ft, input logic [31:0] fd,
                        input bit dr, input bit fl);
        int occ;
        bit a_fire, d_fire, f_ok, f_bad;
        occ    = m_tail - m_head;
        a_fire = av && (occ < DEPTH) && !fl;
        d_fire = dr && (occ > 0) && (m_state[m_head % DEPTH] == 2) && !fl;
        f_ok   = fv && !fl && (m_state[ft] == 1);
        f_bad  = fv && !fl && (m_state[ft] != 1);
        bus.alloc_valid = av;
        bus.fill_valid  = fv;
        bus.fill_tag    = 4'(ft);
        bus.fill_data   = fd;
        bus.drain_ready = dr;
        bus.flush       = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            model_reset();
        end else begin
            if (f_ok) begin
                m_state[ft] = 2;
                m_data[ft]  = fd;
            end
            if (a_fire) begin
                m_state[m_tail % DEPTH] = 1;
                exp_q.push_back(m_tail % DEPTH);
                m_tail++;
            end
            if (d_fire) begin
                m_state[m_head % DEPTH] = 0;
                m_head++;
            end
            m_err = f_bad;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #12;
        total++; if (bus.occupancy !== 5'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
        total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%0b/%0b exp=1/0", bus.empty, bus.full); end
        total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0) begin bad++; $display("FAIL reset_alloc got=%0b/%0d exp=1/0", bus.alloc_ready, bus.alloc_tag); end
        total++; if (bus.drain_valid !== 1'b0 || bus.drain_tag !== 4'd0) begin bad++; $display("FAIL reset_drain got=%0b/%0d exp=0/0", bus.drain_valid, bus.drain_tag); end
        total++; if (bus.fill_err !== 1'b0 || bus.entry_filled !== 16'h0) begin bad++; $display("FAIL reset_err_filled got=%0b/%h exp=0/0000", bus.fill_err, bus.entry_filled); end
        rstn = 1'b1;
    endtask

    task automatic test_fill_all();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (bus.alloc_tag !== 4'(i) || bus.alloc_ready !== 1'b1) begin
                bad++; $display("FAIL fill_all_tag got=%0d/%0b exp=%0d/1", bus.alloc_tag, bus.alloc_ready, i);
            end
            step(1, 0, 0, 0, 0, 0);
        end
        total++; if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_all_full got=%0b/%0b exp=1/0", bus.full, bus.alloc_ready); end
        total++; if (bus.occupancy !== 5'd16) begin bad++; $display("FAIL fill_all_occ got=%0d exp=16", bus.occupancy); end
        step(1, 0, 0, 0, 0, 0);
        total++; if (bus.occupancy !== 5'(m_tail - m_head)) begin bad++; $display("FAIL fill_all_overflow got=%0d exp=%0d", bus.occupancy, m_tail - m_head); end
        step(0, 0, 0, 0, 0, 1);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fill_all_flush got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_out_of_order();
        int          order [4] = '{2, 0, 3, 1};
        logic [31:0] exp_d;
        int          t;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, order[k], 32'hA0 + 32'(order[k]), 0, 0);
            total++;
            if (bus.drain_valid !== (k >= 1)) begin
                bad++; $display("FAIL ooo_drain_valid after_fill=%0d got=%0b exp=%0b", order[k], bus.drain_valid, k >= 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hA0 + 32'(i);
            total++;
            if (bus.drain_valid !== 1'b1 || bus.drain_tag !== 4'(i) || bus.drain_data !== exp_d) begin
                bad++; $display("FAIL ooo_drain got=%0b/%0d/%h exp=1/%0d/%h", bus.drain_valid, bus.drain_tag, bus.drain_data, i, exp_d);
            end
            t = exp_q.pop_front();
            total++;
            if (bus.drain_data !== m_data[t]) begin bad++; $display("FAIL ooo_scoreboard got=%h exp=%h", bus.drain_data, m_data[t]); end
            step(0, 0, 0, 0, 1, 0);
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ooo_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_full_drain_alloc();
        int t;
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 4, 32'hB4, 0, 0);
        total++;
        if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.drain_valid !== 1'b1 || bus.drain_tag !== 4'd4) begin
            bad++; $display("FAIL fda_pre got=%0b/%0b/%0b/%0d exp=1/0/1/4", bus.full, bus.alloc_ready, bus.drain_valid, bus.drain_tag);
        end
        t = exp_q.pop_front();
        total++; if (bus.drain_data !== m_data[t]) begin bad++; $display("FAIL fda_data got=%h exp=%h", bus.drain_data, m_data[t]); end
        step(1, 0, 0, 0, 1, 0);
        total++;
        if (bus.occupancy !== 5'd15 || bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd4) begin
            bad++; $display("FAIL fda_post got=%0d/%0b/%0d exp=15/1/4", bus.occupancy, bus.alloc_ready, bus.alloc_tag);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_fill_err();
        int t;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 5, 32'h55, 0, 0);
        total++; if (bus.fill_err !== 1'b1) begin bad++; $display("FAIL err_free got=%0b exp=1", bus.fill_err); end
        step(0, 1, 1, 32'h11, 0, 0);
        total++; if (bus.fill_err !== 1'b0) begin bad++; $display("FAIL err_good got=%0b exp=0", bus.fill_err); end
        step(0, 1, 1, 32'h22, 0, 0);
        total++; if (bus.fill_err !== 1'b1) begin bad++; $display("FAIL err_refill got=%0b exp=1", bus.fill_err); end
        step(0, 0, 0, 0, 0, 0);
        total++; if (bus.fill_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%0b exp=0", bus.fill_err); end
        step(1, 1, 2, 32'h33, 0, 0);
        total++; if (bus.fill_err !== 1'b1) begin bad++; $display("FAIL err_same_cycle_tag got=%0b exp=1", bus.fill_err); end
        step(0, 1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 2; i++) begin
            t = exp_q.pop_front();
            total++;
            if (bus.drain_valid !== 1'b1 || bus.drain_tag !== 4'(t) || bus.drain_data !== m_data[t]) begin
                bad++; $display("FAIL err_drain got=%0b/%0d/%h exp=1/%0d/%h", bus.drain_valid, bus.drain_tag, bus.drain_data, t, m_data[t]);
            end
            if (i == 1) begin
                total++; if (bus.drain_data !== 32'h11) begin bad++; $display("FAIL err_retained got=%h exp=00000011", bus.drain_data); end
            end
            step(0, 0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_wrap();
        int pend [$];
        int allocs = 0;
        int cyc    = 0;
        int occ, ft, idx, t;
        bit av, fv, dr, exp_dv;
        logic [31:0] fd;
        while ((allocs < 40 || m_tail != m_head) && cyc < 600) begin
            cyc++;
            occ = m_tail - m_head;
            av  = (allocs < 40) && ($urandom_range(0, 3) != 0);
            fv  = 0; ft = 0; fd = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, pend.size() - 1);
                ft  = pend[idx];
                pend.delete(idx);
                fv  = 1;
            end
            dr = ($urandom_range(0, 3) != 0);
            if (av && occ < DEPTH) begin
                total++;
                if (bus.alloc_tag !== 4'(m_tail % DEPTH)) begin
                    bad++; $display("FAIL wrap_alloc_tag got=%0d exp=%0d", bus.alloc_tag, m_tail % DEPTH);
                end
                pend.push_back(m_tail % DEPTH);
                allocs++;
            end
            exp_dv = (occ > 0) && (m_state[m_head % DEPTH] == 2);
            total++;
            if (bus.drain_valid !== exp_dv) begin bad++; $display("FAIL wrap_drain_valid got=%0b exp=%0b", bus.drain_valid, exp_dv); end
            if (exp_dv && dr) begin
                t = exp_q.pop_front();
                total++;
                if (bus.drain_tag !== 4'(t) || bus.drain_data !== m_data[t]) begin
                    bad++; $display("FAIL wrap_drain got=%0d/%h exp=%0d/%h", bus.drain_tag, bus.drain_data, t, m_data[t]);
                end
            end
            step(av, fv, ft, fd, dr, 0);
            total++;
            if (bus.occupancy !== 5'(m_tail - m_head) || (bus.full && bus.empty) || bus.fill_err !== m_err) begin
                bad++; $display("FAIL wrap_status got=%0d/%0b/%0b/%0b exp=%0d/-/-/%0b", bus.occupancy, bus.full, bus.empty, bus.fill_err, m_tail - m_head, m_err);
            end
        end
        total++;
        if (allocs != 40 || m_tail != m_head) begin
            bad++; $display("FAIL wrap_budget got=%0d allocs left=%0d exp=40/0", allocs, m_tail - m_head);
        end
    endtask

    task automatic test_flush_reset();
        int t0;
        t0 = m_tail % DEPTH;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, (t0 + i) % DEPTH, 32'hC0 + 32'(i), 0, 0);
        step(1, 1, (t0 + 3) % DEPTH, 32'hEE, 1, 1);
        total++; if (bus.empty !== 1'b1 || bus.occupancy !== 5'd0) begin bad++; $display("FAIL flush_empty got=%0b/%0d exp=1/0", bus.empty, bus.occupancy); end
        total++; if (bus.entry_filled !== 16'h0 || bus.fill_err !== 1'b0) begin bad++; $display("FAIL flush_filled_err got=%h/%0b exp=0000/0", bus.entry_filled, bus.fill_err); end
        total++; if (bus.alloc_tag !== 4'd0 || bus.drain_valid !== 1'b0) begin bad++; $display("FAIL flush_ptrs got=%0d/%0b exp=0/0", bus.alloc_tag, bus.drain_valid); end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'hD0, 0, 0);
        step(0, 1, 9, 32'hD9, 0, 0);
        total++;
        if (bus.fill_err !== 1'b1 || bus.drain_valid !== 1'b1 || bus.occupancy !== 5'd3) begin
            bad++; $display("FAIL pre_reset got=%0b/%0b/%0d exp=1/1/3", bus.fill_err, bus.drain_valid, bus.occupancy);
        end
        #2 rstn = 1'b0;
        #1;
        total++; if (bus.occupancy !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL async_reset_occ got=%0d/%0b/%0b exp=0/1/0", bus.occupancy, bus.empty, bus.full); end
        total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 4'd0 || bus.drain_tag !== 4'd0) begin bad++; $display("FAIL async_reset_ptrs got=%0b/%0d/%0d exp=1/0/0", bus.alloc_ready, bus.alloc_tag, bus.drain_tag); end
        total++; if (bus.drain_valid !== 1'b0 || bus.fill_err !== 1'b0 || bus.entry_filled !== 16'h0) begin bad++; $display("FAIL async_reset_flags got=%0b/%0b/%h exp=0/0/0000", bus.drain_valid, bus.fill_err, bus.entry_filled); end
        model_reset();
        #3 rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_fill_all();
        test_out_of_order();
        test_full_drain_alloc();
        test_fill_err();
        test_wrap();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
